// File: rtl/fu_issue_ctrl_pkg.sv
// Shared definitions for the FU issue controller: FSM states and default widths/latencies.
package fu_issue_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } fu_state_t;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned TAG_W_DEF  = 5;
   localparam int unsigned FU_MUL_LAT = 7;

endpackage

// File: rtl/fu_issue_ctrl_result_fifo.sv
// fu_result_fifo: DEPTH-entry result queue with synchronous clear (clear beats push/pop).
module fu_result_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned W     = 37
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   clear,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           din,
   output logic [$clog2(DEPTH):0] count,
   output logic [W-1:0]           head,
   output logic                   valid
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign valid   = (count != '0);
   assign head    = mem[rd_ptr];
   assign do_pop  = pop & valid;
   assign do_push = push & ((count < CW'(DEPTH)) | do_pop);

   // DEPTH is a power of two, so pointer wrap is the natural binary rollover
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/fu_issue_ctrl.sv
// fu_issue_ctrl: initiator side of a multi-cycle FU EN/finish handshake, one op in flight,
// results queued in fu_result_fifo toward writeback.
module fu_issue_ctrl
   import fu_issue_ctrl_pkg::*;
#(
   parameter int unsigned FU_LAT  = FU_MUL_LAT,
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned TAG_W   = TAG_W_DEF,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   input  logic [TAG_W-1:0]  req_tag,
   input  logic              flush,
   output logic              fu_en,
   output logic [DATA_W-1:0] fu_a,
   output logic [DATA_W-1:0] fu_b,
   input  logic [DATA_W-1:0] fu_res,
   input  logic              fu_finish,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [DATA_W-1:0] wb_data,
   output logic [TAG_W-1:0]  wb_tag,
   output logic              err_timeout
);

   localparam int unsigned CW  = $clog2(DEPTH) + 1;
   localparam int unsigned TCW = $clog2(TIMEOUT + 1);
   localparam int unsigned RW  = DATA_W + TAG_W;

   if ((TIMEOUT <= FU_LAT) || (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_param_check
      $error("fu_issue_ctrl: illegal parameter combination");
   end

   fu_state_t        state;
   fu_state_t        state_nxt;
   logic [TCW-1:0]   wait_cnt;
   logic [TCW-1:0]   wait_cnt_nxt;
   logic             drop;
   logic             drop_nxt;
   logic             push;
   logic             timeout_hit;
   logic             fire;
   logic [TAG_W-1:0] tag_q;
   logic [CW-1:0]    fifo_count;
   logic [RW-1:0]    fifo_head;

   assign req_ready = (state == ST_IDLE) & ~flush & (fifo_count < CW'(DEPTH));
   assign fire      = req_valid & req_ready;

   // drop marks an in-flight op whose result must be thrown away; it is cleared
   // whenever WAIT is left so it never leaks into the next op
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      drop_nxt     = drop;
      push         = 1'b0;
      timeout_hit  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (fire) state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = '0;
            if (flush) drop_nxt = 1'b1;
         end
         ST_WAIT: begin
            if (fu_finish) begin
               push      = ~drop & ~flush;
               drop_nxt  = 1'b0;
               state_nxt = ST_IDLE;
            end else if (wait_cnt == TCW'(TIMEOUT - 1)) begin
               timeout_hit  = 1'b1;
               drop_nxt     = 1'b0;
               wait_cnt_nxt = '0;
               state_nxt    = ST_IDLE;
            end else begin
               wait_cnt_nxt = wait_cnt + TCW'(1);
               if (flush) drop_nxt = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= ST_IDLE;
         wait_cnt    <= '0;
         drop        <= 1'b0;
         err_timeout <= 1'b0;
         tag_q       <= '0;
         fu_en       <= 1'b0;
         fu_a        <= '0;
         fu_b        <= '0;
      end else begin
         state       <= state_nxt;
         wait_cnt    <= wait_cnt_nxt;
         drop        <= drop_nxt;
         err_timeout <= err_timeout | timeout_hit;
         fu_en       <= fire;
         if (fire) begin
            tag_q <= req_tag;
            fu_a  <= req_a;
            fu_b  <= req_b;
         end
      end
   end

   fu_result_fifo #(
      .DEPTH (DEPTH),
      .W     (RW)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .clear (flush),
      .push  (push),
      .pop   (wb_ready),
      .din   ({fu_res, tag_q}),
      .count (fifo_count),
      .head  (fifo_head),
      .valid (wb_valid)
   );

   assign wb_data = fifo_head[RW-1:TAG_W];
   assign wb_tag  = fifo_head[TAG_W-1:0];

endmodule

// File: tb/tb_fu_issue_ctrl.sv
// Bench for fu_issue_ctrl with an attached FU_mul model; directed scenarios plus a
// randomized run against a cycle-count based reference model.
module tb_fu_issue_ctrl;

   localparam int FU_LAT  = 7;
   localparam int DEPTH   = 2;
   localparam int TAG_W   = 5;
   localparam int TIMEOUT = 64;
   localparam int RW      = 32 + TAG_W;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [31:0]      req_a = '0;
   logic [31:0]      req_b = '0;
   logic [TAG_W-1:0] req_tag = '0;
   logic             flush = 1'b0;
   logic             fu_en;
   logic [31:0]      fu_a;
   logic [31:0]      fu_b;
   logic [31:0]      fu_res;
   logic             fu_finish;
   logic             wb_valid;
   logic             wb_ready = 1'b0;
   logic [31:0]      wb_data;
   logic [TAG_W-1:0] wb_tag;
   logic             err_timeout;

   int vectors = 0;
   int miscompares = 0;

   bit          fu_hang = 1'b0;
   int          stray_cyc = -1;
   int          fu_cyc = 0;
   bit          fu_busy = 1'b0;
   int          fu_cnt = 0;
   logic [31:0] fu_prod = '0;

   fu_issue_ctrl #(
      .FU_LAT  (FU_LAT),
      .DEPTH   (DEPTH),
      .TAG_W   (TAG_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_tag     (req_tag),
      .flush       (flush),
      .fu_en       (fu_en),
      .fu_a        (fu_a),
      .fu_b        (fu_b),
      .fu_res      (fu_res),
      .fu_finish   (fu_finish),
      .wb_valid    (wb_valid),
      .wb_ready    (wb_ready),
      .wb_data     (wb_data),
      .wb_tag      (wb_tag),
      .err_timeout (err_timeout)
   );

   initial forever #5 clk = ~clk;

   // FU_mul model: finish pulse FU_LAT cycles after the fu_en cycle; reset with rstn
   initial begin
      fu_finish = 1'b0;
      fu_res    = '0;
      forever begin
         @(posedge clk);
         #1;
         fu_cyc++;
         fu_finish = 1'b0;
         fu_res    = $urandom;
         if (!rstn) begin
            fu_busy = 1'b0;
         end else begin
            if (fu_busy) begin
               fu_cnt--;
               if (fu_cnt == 0) begin
                  fu_busy = 1'b0;
                  if (!fu_hang) begin
                     fu_finish = 1'b1;
                     fu_res    = fu_prod;
                  end
               end
            end
            if (fu_en) begin
               fu_busy = 1'b1;
               fu_cnt  = FU_LAT;
               fu_prod = fu_a * fu_b;
            end
         end
         if (fu_cyc == stray_cyc) fu_finish = 1'b1;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic issue_wait(input logic [31:0] a, input logic [31:0] b,
                             input logic [TAG_W-1:0] t, output bit ok);
      req_a = a; req_b = b; req_tag = t; req_valid = 1'b1; ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         #1;
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      if (ok) step();
      req_valid = 1'b0;
   endtask

   task automatic wait_wb(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (wb_valid) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      step();
      vectors++; if (fu_en !== 1'b0) begin miscompares++; $display("FAIL reset_fu_en got=%0b exp=0", fu_en); end
      vectors++; if (fu_a !== 32'h0 || fu_b !== 32'h0) begin miscompares++; $display("FAIL reset_fu_ops got=%h/%h exp=0/0", fu_a, fu_b); end
      vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL reset_wb_valid got=%0b exp=0", wb_valid); end
      vectors++; if (wb_data !== 32'h0 || wb_tag !== 5'h0) begin miscompares++; $display("FAIL reset_wb_head got=%h/%h exp=0/0", wb_data, wb_tag); end
      vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%0b exp=0", err_timeout); end
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
      rstn = 1'b1;
      step();
   endtask

   task automatic test_single_op();
      bit ok;
      issue_wait(32'd3, 32'd5, 5'd4, ok);
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL single_accept got=%0b exp=1", ok); end
      vectors++; if (fu_en !== 1'b1 || fu_a !== 32'd3 || fu_b !== 32'd5) begin miscompares++; $display("FAIL single_issue got=%0b %0d %0d exp=1 3 5", fu_en, fu_a, fu_b); end
      for (int k = 2; k <= 8; k++) begin
         step();
         vectors++; if (fu_en !== 1'b0 || wb_valid !== 1'b0) begin miscompares++; $display("FAIL single_wait t=%0d got=%0b/%0b exp=0/0", k, fu_en, wb_valid); end
      end
      step();
      vectors++; if (wb_valid !== 1'b1 || wb_data !== 32'd15 || wb_tag !== 5'd4) begin miscompares++; $display("FAIL single_result got=%0b %0d %0d exp=1 15 4", wb_valid, wb_data, wb_tag); end
      wb_ready = 1'b1;
      step();
      wb_ready = 1'b0;
      vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL single_pop got=%0b exp=0", wb_valid); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      wb_ready = 1'b1;
      issue_wait(32'hFFFF_FFFF, 32'd2, 5'd1, ok);
      req_a = 32'd7; req_b = 32'd6; req_tag = 5'd2; req_valid = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_busy t=%0d got=%0b exp=0", k, req_ready); end
         step();
      end
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_t9 got=%0b exp=1", req_ready); end
      vectors++; if (wb_valid !== 1'b1 || wb_data !== 32'hFFFF_FFFE || wb_tag !== 5'd1) begin miscompares++; $display("FAIL b2b_first got=%0b %h %0d exp=1 fffffffe 1", wb_valid, wb_data, wb_tag); end
      step();
      req_valid = 1'b0;
      vectors++; if (fu_en !== 1'b1 || fu_a !== 32'd7 || fu_b !== 32'd6) begin miscompares++; $display("FAIL b2b_issue2 got=%0b %0d %0d exp=1 7 6", fu_en, fu_a, fu_b); end
      for (int k = 0; k < 8; k++) step();
      vectors++; if (wb_valid !== 1'b1 || wb_data !== 32'd42 || wb_tag !== 5'd2) begin miscompares++; $display("FAIL b2b_second got=%0b %0d %0d exp=1 42 2", wb_valid, wb_data, wb_tag); end
      step();
      wb_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [31:0] a[3], b[3];
      for (int i = 0; i < 3; i++) begin a[i] = $urandom; b[i] = $urandom_range(1, 1000); end
      wb_ready = 1'b0;
      issue_wait(a[0], b[0], 5'd10, ok);
      issue_wait(a[1], b[1], 5'd11, ok);
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL bp_accept2 got=%0b exp=1", ok); end
      req_a = a[2]; req_b = b[2]; req_tag = 5'd12; req_valid = 1'b1;
      for (int k = 0; k < 12; k++) begin
         vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_blocked k=%0d got=%0b exp=0", k, req_ready); end
         step();
      end
      vectors++; if (wb_valid !== 1'b1 || wb_data !== a[0] * b[0] || wb_tag !== 5'd10) begin miscompares++; $display("FAIL bp_head1 got=%h %0d exp=%h 10", wb_data, wb_tag, a[0] * b[0]); end
      wb_ready = 1'b1;
      step();
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_after_pop got=%0b exp=1", req_ready); end
      vectors++; if (wb_data !== a[1] * b[1] || wb_tag !== 5'd11) begin miscompares++; $display("FAIL bp_head2 got=%h %0d exp=%h 11", wb_data, wb_tag, a[1] * b[1]); end
      step();
      req_valid = 1'b0;
      vectors++; if (fu_en !== 1'b1) begin miscompares++; $display("FAIL bp_issue3 got=%0b exp=1", fu_en); end
      wait_wb(20, ok);
      vectors++; if (!ok || wb_data !== a[2] * b[2] || wb_tag !== 5'd12) begin miscompares++; $display("FAIL bp_result3 got=%0b %h %0d exp=1 %h 12", ok, wb_data, wb_tag, a[2] * b[2]); end
      step();
      wb_ready = 1'b0;
   endtask

   task automatic test_flush();
      bit ok;
      wb_ready = 1'b0;
      issue_wait(32'd2, 32'd2, 5'd3, ok);
      wait_wb(20, ok);
      issue_wait(32'd100, 32'd3, 5'd7, ok);
      step(); step(); step();
      vectors++; if (wb_valid !== 1'b1) begin miscompares++; $display("FAIL flush_queued got=%0b exp=1", wb_valid); end
      flush = 1'b1;
      step();
      flush = 1'b0;
      for (int k = 5; k <= 8; k++) begin
         vectors++; if (wb_valid !== 1'b0 || req_ready !== 1'b0) begin miscompares++; $display("FAIL flush_wait t=%0d got=%0b/%0b exp=0/0", k, wb_valid, req_ready); end
         step();
      end
      vectors++; if (req_ready !== 1'b1 || wb_valid !== 1'b0) begin miscompares++; $display("FAIL flush_t9 got=%0b/%0b exp=1/0", req_ready, wb_valid); end
      flush = 1'b1; req_valid = 1'b1; req_a = 32'd5; req_b = 32'd5; req_tag = 5'd9;
      #1;
      vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL flush_blocks_req got=%0b exp=0", req_ready); end
      step();
      flush = 1'b0; req_valid = 1'b0;
      vectors++; if (fu_en !== 1'b0) begin miscompares++; $display("FAIL flush_no_issue got=%0b exp=0", fu_en); end
      for (int k = 0; k < 4; k++) step();
      vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL flush_nothing_written got=%0b exp=0", wb_valid); end
   endtask

   task automatic test_timeout();
      bit ok;
      bit any_valid = 1'b0;
      int rise = -1;
      fu_hang = 1'b1;
      issue_wait(32'd8, 32'd8, 5'd6, ok);
      vectors++; if (fu_en !== 1'b1) begin miscompares++; $display("FAIL to_issue got=%0b exp=1", fu_en); end
      for (int k = 1; k <= TIMEOUT + 6; k++) begin
         if (err_timeout === 1'b1 && rise < 0) rise = k;
         if (wb_valid !== 1'b0) any_valid = 1'b1;
         step();
      end
      fu_hang = 1'b0;
      vectors++; if (rise < TIMEOUT || rise > TIMEOUT + 3) begin miscompares++; $display("FAIL to_rise_cycle got=%0d exp=%0d..%0d", rise, TIMEOUT, TIMEOUT + 3); end
      vectors++; if (any_valid !== 1'b0) begin miscompares++; $display("FAIL to_no_push got=%0b exp=0", any_valid); end
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL to_idle got=%0b exp=1", req_ready); end
      issue_wait(32'd12, 32'd12, 5'd13, ok);
      wait_wb(20, ok);
      vectors++; if (!ok || wb_data !== 32'd144 || wb_tag !== 5'd13) begin miscompares++; $display("FAIL to_next_op got=%0b %0d %0d exp=1 144 13", ok, wb_data, wb_tag); end
      vectors++; if (err_timeout !== 1'b1) begin miscompares++; $display("FAIL to_sticky got=%0b exp=1", err_timeout); end
      wb_ready = 1'b1;
      step();
      wb_ready = 1'b0;
   endtask

   task automatic test_reset_mid_op();
      bit ok;
      issue_wait(32'd20, 32'd30, 5'd14, ok);
      step(); step();
      rstn = 1'b0;
      stray_cyc = fu_cyc + 5;
      #1;
      vectors++; if (fu_en !== 1'b0 || fu_a !== 32'h0 || fu_b !== 32'h0) begin miscompares++; $display("FAIL rmid_fu got=%0b %h %h exp=0 0 0", fu_en, fu_a, fu_b); end
      vectors++; if (wb_valid !== 1'b0 || wb_data !== 32'h0 || wb_tag !== 5'h0) begin miscompares++; $display("FAIL rmid_wb got=%0b %h %h exp=0 0 0", wb_valid, wb_data, wb_tag); end
      vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL rmid_err got=%0b exp=0", err_timeout); end
      step(); step();
      rstn = 1'b1;
      step(); step(); step();
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_idle got=%0b exp=1", req_ready); end
      step();
      vectors++; if (wb_valid !== 1'b0 || fu_en !== 1'b0) begin miscompares++; $display("FAIL rmid_stray got=%0b/%0b exp=0/0", wb_valid, fu_en); end
      issue_wait(32'd9, 32'd11, 5'd31, ok);
      wait_wb(20, ok);
      vectors++; if (!ok || wb_data !== 32'd99 || wb_tag !== 5'd31) begin miscompares++; $display("FAIL rmid_new_op got=%0b %0d %0d exp=1 99 31", ok, wb_data, wb_tag); end
      wb_ready = 1'b1;
      step();
      wb_ready = 1'b0;
   endtask

   // Reference: an op accepted in cycle t finishes in cycle t+1+FU_LAT; the FSM is busy
   // until then; a flush in t+1..t+1+FU_LAT discards it; the queue holds up to DEPTH.
   task automatic test_random();
      logic [RW-1:0]    q[$];
      logic [RW-1:0]    head;
      bit               op_act = 1'b0;
      bit               op_drop = 1'b0;
      bit               fl, rv, wr, exp_ready, fin, exp_en;
      int               op_t = 0;
      logic [31:0]      op_a = '0, op_b = '0, op_res = '0, a, b;
      logic [TAG_W-1:0] op_tag = '0, t;
      for (int c = 0; c < 1500; c++) begin
         vectors++; if (wb_valid !== (q.size() != 0)) begin miscompares++; $display("FAIL rnd_wb_valid c=%0d got=%0b exp=%0b", c, wb_valid, q.size() != 0); end
         if (q.size() != 0) begin
            head = q[0];
            vectors++; if (wb_data !== head[RW-1:TAG_W] || wb_tag !== head[TAG_W-1:0]) begin miscompares++; $display("FAIL rnd_wb_head c=%0d got=%h/%0d exp=%h/%0d", c, wb_data, wb_tag, head[RW-1:TAG_W], head[TAG_W-1:0]); end
         end
         exp_en = op_act && (c == op_t + 1);
         vectors++; if (fu_en !== exp_en) begin miscompares++; $display("FAIL rnd_fu_en c=%0d got=%0b exp=%0b", c, fu_en, exp_en); end
         if (exp_en) begin
            vectors++; if (fu_a !== op_a || fu_b !== op_b) begin miscompares++; $display("FAIL rnd_fu_ops c=%0d got=%h/%h exp=%h/%h", c, fu_a, fu_b, op_a, op_b); end
         end
         vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL rnd_err c=%0d got=%0b exp=0", c, err_timeout); end

         rv = ($urandom_range(0, 3) != 0);
         a  = $urandom;
         b  = $urandom;
         t  = TAG_W'($urandom);
         wr = ($urandom_range(0, 2) != 0);
         fl = ($urandom_range(0, 29) == 0);
         req_valid = rv; req_a = a; req_b = b; req_tag = t; wb_ready = wr; flush = fl;
         #1;
         exp_ready = !(op_act && c <= op_t + 1 + FU_LAT) && !fl && (q.size() < DEPTH);
         vectors++; if (req_ready !== exp_ready) begin miscompares++; $display("FAIL rnd_req_ready c=%0d got=%0b exp=%0b", c, req_ready, exp_ready); end

         fin = op_act && (c == op_t + 1 + FU_LAT);
         if (fl) begin
            q.delete();
            if (op_act) op_drop = 1'b1;
         end else begin
            if (wr && q.size() != 0) void'(q.pop_front());
            if (fin && !op_drop) q.push_back({op_res, op_tag});
         end
         if (fin) op_act = 1'b0;
         if (rv && exp_ready) begin
            op_act = 1'b1; op_t = c; op_drop = 1'b0;
            op_a = a; op_b = b; op_res = a * b; op_tag = t;
         end
         step();
      end
      req_valid = 1'b0; flush = 1'b0; wb_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_timeout();
      test_reset_mid_op();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
